// File: rtl/clock_ratio_meter_pkg.sv
// Shared constants for the clock ratio meter: FSM encodings and default sizing.
package clock_ratio_meter_pkg;

   localparam int unsigned DEFAULT_WIDTH       = 16;
   localparam int unsigned DEFAULT_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      WAIT_EDGE = 2'd0,
      MEAS_HIGH = 2'd1,
      MEAS_LOW  = 2'd2
   } meas_state_t;

endpackage

// File: rtl/clock_ratio_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, with one-cycle rise/fall pulses
// derived from the synchronized level and its registered copy.
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic in_clock,
   input  logic reset,
   input  logic async_in,
   output logic rise_c,
   output logic fall_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level_d_q;
   logic                   level;

   always_ff @(posedge in_clock or posedge reset) begin
      if (reset) begin
         sync_q    <= '0;
         level_d_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
         level_d_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level  = sync_q[SYNC_STAGES-1];
   assign rise_c = level & ~level_d_q;
   assign fall_c = ~level & level_d_q;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures high/low phase lengths of meas_clock in in_clock cycles, recovers the
// divider setting that produced it, and flags lock and stall conditions.
module clock_ratio_meter
   import clock_ratio_meter_pkg::*;
#(
   parameter int unsigned WIDTH       = DEFAULT_WIDTH,
   parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic             in_clock,
   input  logic             reset,
   input  logic             meas_clock,
   input  logic             enable,
   output logic [WIDTH-1:0] high_len,
   output logic [WIDTH-1:0] low_len,
   output logic [WIDTH-1:0] divider_est,
   output logic             symmetric,
   output logic             valid,
   output logic             locked,
   output logic             stalled
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   meas_state_t      state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hl_tmp_q, hl_tmp_d;
   logic [WIDTH-1:0] high_len_q, high_len_d;
   logic [WIDTH-1:0] low_len_q, low_len_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic             sym_q, sym_d;
   logic             valid_q, valid_d;
   logic             locked_q, locked_d;
   logic             stalled_q, stalled_d;

   logic             rise_c, fall_c;
   logic             cnt_at_max_c;
   logic [WIDTH-1:0] cnt_inc_c;
   logic [WIDTH:0]   sum_c;
   logic             pub_sym_c;
   logic [WIDTH-1:0] pub_div_c;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .in_clock(in_clock),
      .reset   (reset),
      .async_in(meas_clock),
      .rise_c  (rise_c),
      .fall_c  (fall_c)
   );

   // Saturating counter: the step that lands on CNT_MAX is the stall point.
   assign cnt_at_max_c = (cnt_q >= (CNT_MAX - CNT_ONE));
   assign cnt_inc_c    = cnt_at_max_c ? CNT_MAX : (cnt_q + CNT_ONE);

   // Divider estimate for the period being published (high = hl_tmp_q, low = cnt_q).
   assign sum_c     = (WIDTH+1)'(hl_tmp_q) + (WIDTH+1)'(cnt_q);
   assign pub_sym_c = (hl_tmp_q == cnt_q);
   assign pub_div_c = pub_sym_c ? (hl_tmp_q - CNT_ONE) : (sum_c[WIDTH:1] - CNT_ONE);

   always_ff @(posedge in_clock or posedge reset) begin
      if (reset) begin
         state_q    <= WAIT_EDGE;
         cnt_q      <= '0;
         hl_tmp_q   <= '0;
         high_len_q <= '0;
         low_len_q  <= '0;
         div_q      <= '0;
         sym_q      <= 1'b0;
         valid_q    <= 1'b0;
         locked_q   <= 1'b0;
         stalled_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hl_tmp_q   <= hl_tmp_d;
         high_len_q <= high_len_d;
         low_len_q  <= low_len_d;
         div_q      <= div_d;
         sym_q      <= sym_d;
         valid_q    <= valid_d;
         locked_q   <= locked_d;
         stalled_q  <= stalled_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hl_tmp_d   = hl_tmp_q;
      high_len_d = high_len_q;
      low_len_d  = low_len_q;
      div_d      = div_q;
      sym_d      = sym_q;
      valid_d    = 1'b0;
      locked_d   = locked_q;
      stalled_d  = stalled_q;

      if (!enable) begin
         state_d  = WAIT_EDGE;
         cnt_d    = '0;
         locked_d = 1'b0;
      end else begin
         if (rise_c) begin
            stalled_d = 1'b0;
         end
         unique case (state_q)
            WAIT_EDGE: begin
               if (rise_c) begin
                  state_d = MEAS_HIGH;
                  cnt_d   = CNT_ONE;
               end else begin
                  cnt_d = cnt_inc_c;
                  if (cnt_at_max_c) begin
                     stalled_d = 1'b1;
                     locked_d  = 1'b0;
                  end
               end
            end
            MEAS_HIGH: begin
               if (fall_c) begin
                  hl_tmp_d = cnt_q;
                  cnt_d    = CNT_ONE;
                  state_d  = MEAS_LOW;
               end else if (cnt_at_max_c) begin
                  cnt_d     = CNT_MAX;
                  stalled_d = 1'b1;
                  locked_d  = 1'b0;
                  state_d   = WAIT_EDGE;
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end
            MEAS_LOW: begin
               if (rise_c) begin
                  high_len_d = hl_tmp_q;
                  low_len_d  = cnt_q;
                  sym_d      = pub_sym_c;
                  div_d      = pub_div_c;
                  valid_d    = 1'b1;
                  locked_d   = (hl_tmp_q == high_len_q) && (cnt_q == low_len_q);
                  cnt_d      = CNT_ONE;
                  state_d    = MEAS_HIGH;
               end else if (cnt_at_max_c) begin
                  cnt_d     = CNT_MAX;
                  stalled_d = 1'b1;
                  locked_d  = 1'b0;
                  state_d   = WAIT_EDGE;
               end else begin
                  cnt_d = cnt_inc_c;
               end
            end
            default: begin
               state_d = WAIT_EDGE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign high_len    = high_len_q;
   assign low_len     = low_len_q;
   assign divider_est = div_q;
   assign symmetric   = sym_q;
   assign valid       = valid_q;
   assign locked      = locked_q;
   assign stalled     = stalled_q;

endmodule
